lcd_refresh_ctrl: RTL and testbench
===================================

// Module: lcd_refresh_ctrl
// PURPOSE
//  Sequencer for the HD44780 strobe-level LCD FSM in wb_lcd. Holds a 2x16 character shadow
//  buffer written by the bus side and replays dirty lines to the LCD. It issues init/dr/wr strobes
//  with hold and settle times, so software never has to poll LCD timing.
//  Sits between the wishbone slave registers and the strobe FSM.
// PARAMETERS
//  T_PWRUP   150000  clk cycles after reset before first init (15 ms @ 10 MHz)
//  T_INIT    20000   cycles from init strobe start to next command (covers fn-set, on, clear)
//  T_CMD     400     cycles from dr/wr strobe start to next strobe (40 us)
//  STRB_CYC  8       cycles a strobe is held high; >= 2 periods of the slow FSM state clock
// PORTS
//  clk        in   1  system clock (10 MHz)
//  rst_n      in   1  synchronous active-low reset
//  buf_we     in   1  write one character into the shadow buffer this cycle
//  buf_addr   in   5  {line, column[3:0]}; line 0 = top, line 1 = bottom
//  buf_data   in   8  character code
//  reinit     in   1  one-cycle request to re-run LCD init
//  ready      out  1  high once the first init has completed; stays high
//  busy       out  1  high whenever state != IDLE
//  lcd_init   out  1  init strobe to the LCD FSM
//  lcd_dr     out  1  set-DDRAM-address strobe
//  lcd_wr     out  1  data-write strobe
//  lcd_direc  out  8  address command byte, valid whenever lcd_dr = 1
//  lcd_dbi    out  8  character byte, valid whenever lcd_wr = 1
// BEHAVIOUR
//  Reset (rst_n = 0 at clk edge, any state):
//   - state = PWRUP; all strobes, ready, lcd_direc, lcd_dbi = 0; busy = 1.
//   - Buffer cleared to 0x20; dirty = 2'b00; reinit_pend = 0.
//  FSM (registered outputs; one wait counter, 18 bits):
//   - PWRUP: count T_PWRUP -> INIT_S.
//   - INIT_S: lcd_init = 1 for STRB_CYC cycles, then INIT_W.
//   - INIT_W: wait until T_INIT cycles have elapsed since strobe start.
//     Then ready = 1, dirty = 2'b11, reinit_pend = 0 -> IDLE.
//   - IDLE: priority reinit_pend > dirty[0] > dirty[1].
//     For a dirty line: latch line, clear dirty[line], col = 0 -> ADDR_S.
//   - ADDR_S: lcd_direc = 8'h80 | {line, 6'b0} (0x80 / 0xC0); lcd_dr = 1 for STRB_CYC -> ADDR_W.
//   - ADDR_W: T_CMD elapsed since strobe start -> CHAR_S.
//   - CHAR_S: lcd_dbi = buf[{line, col}] registered on entry; lcd_wr = 1 for STRB_CYC -> CHAR_W.
//   - CHAR_W: T_CMD elapsed. If col = 15 -> IDLE, else col++ -> CHAR_S.
//  Strobe rules:
//   - At most one of lcd_init/lcd_dr/lcd_wr is high in any cycle.
//   - Data bytes are stable for the whole high phase and for 1 cycle after it.
//  Buffer write:
//   - Accepted every cycle in every state except during reset; no back-pressure.
//   - Sets dirty[buf_addr[4]].
//   - A write to the line being sent re-dirties it; the line is resent in full afterwards.
//  Simultaneous events:
//   - Write in the same cycle IDLE clears that line's dirty bit -> set wins.
//   - Write to a column not yet sent on the active line is visible in this pass (buf read at CHAR_S entry).
//  reinit:
//   - Latched into reinit_pend in any state.
//   - Honoured only from IDLE; an active line pass is never truncated.
//   - In PWRUP/INIT_*, it is absorbed by the pending init.
//  Strobe-to-strobe spacing is >= T_CMD (>= T_INIT after init).
//  Wait counter compares with ">=" so parameter values of 0 collapse a wait to 1 cycle.
// STRUCTURE
//  Shared package lcd_pkg:
//   - State enum.
//   - LCD_CMD_DDRAM = 8'h80, LCD_LINE2_OFS = 8'h40, LCD_BLANK = 8'h20.
//   - Column/line widths (COL_W = 4, LINE_W = 1).
//  Sub-module lcd_char_buf: 32x8 flop array with sync write/reset, async read, 2-bit dirty
//  register with set-over-clear.
//  Top level holds the FSM, wait counter, column counter, reinit latch.
// TESTING
//  1. Release rst_n -> no strobe for T_PWRUP cycles; lcd_init high exactly STRB_CYC cycles;
//     ready rises T_INIT later; both lines sent as 0x20 x16.
//  2. After idle, write 'A' (0x41) to addr 5'h13 -> lcd_dr with lcd_direc = 0xC0, then 16 lcd_wr;
//     the 4th carries 0x41. Line 0 untouched.
//  3. Write addr 0 and 5'h10 in the same cycle while idle -> line 0 pass (0x80), then line 1 pass (0xC0),
//     in that order.
//  4. During line-0 CHAR_W at col 3, write col 10 then col 1 -> col 10 new value in this pass;
//     the line is resent once more with col 1 updated.
//  5. Pulse reinit during a line pass -> pass completes all 16 chars, then lcd_init strobe,
//     then full refresh of both lines.
//  6. Deassert rst_n mid CHAR_S -> next cycle all strobes 0, ready 0, busy 1; power-up sequence restarts.
//     Assert strobe exclusivity and min spacing throughout.

Source files
------------

// File: rtl/lcd_pkg.sv
// Shared types and constants for the HD44780 refresh sequencer and its shadow buffer.
package lcd_pkg;
  localparam int COL_W  = 4;
  localparam int LINE_W = 1;
  localparam int BUF_AW = LINE_W + COL_W;
  localparam int CNT_W  = 18;

  localparam logic [7:0] LCD_CMD_DDRAM = 8'h80;
  localparam logic [7:0] LCD_LINE2_OFS = 8'h40;
  localparam logic [7:0] LCD_BLANK     = 8'h20;

  typedef enum logic [2:0] {
    ST_PWRUP  = 3'd0,
    ST_INIT_S = 3'd1,
    ST_INIT_W = 3'd2,
    ST_IDLE   = 3'd3,
    ST_ADDR_S = 3'd4,
    ST_ADDR_W = 3'd5,
    ST_CHAR_S = 3'd6,
    ST_CHAR_W = 3'd7
  } lcd_state_e;

  // Set-DDRAM-address command for the start of a display line.
  function automatic logic [7:0] ddram_cmd(input logic line);
    return LCD_CMD_DDRAM | (line ? LCD_LINE2_OFS : 8'h00);
  endfunction
endpackage

// File: rtl/lcd_char_buf.sv
// 2x16 character shadow buffer with per-line dirty flags; a set always beats a clear.
module lcd_char_buf
  import lcd_pkg::*;
(
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_we,
  input  logic [BUF_AW-1:0] i_waddr,
  input  logic [7:0]        i_wdata,
  input  logic [BUF_AW-1:0] i_raddr,
  output logic [7:0]        o_rdata,
  input  logic              i_clr_en,
  input  logic              i_clr_line,
  input  logic              i_set_all,
  output logic [1:0]        o_dirty
);
  logic [7:0] r_mem [2**BUF_AW];
  logic [1:0] r_dirty;
  logic [1:0] w_set;
  logic [1:0] w_clr;

  always_comb begin
    w_set = {2{i_set_all}};
    w_clr = 2'b00;
    if (i_we)     w_set[i_waddr[BUF_AW-1]] = 1'b1;
    if (i_clr_en) w_clr[i_clr_line] = 1'b1;
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      for (int i = 0; i < 2**BUF_AW; i++) r_mem[i] <= LCD_BLANK;
      r_dirty <= 2'b00;
    end else begin
      if (i_we) r_mem[i_waddr] <= i_wdata;
      r_dirty <= (r_dirty & ~w_clr) | w_set;
    end
  end

  assign o_rdata = r_mem[i_raddr];
  assign o_dirty = r_dirty;
endmodule

// File: rtl/lcd_refresh_ctrl.sv
// Replays dirty shadow-buffer lines to the strobe-level LCD FSM, pacing init/dr/wr strobes
// with fixed hold and settle times so the bus side never polls LCD timing.
module lcd_refresh_ctrl
  import lcd_pkg::*;
#(
  parameter int unsigned T_PWRUP  = 150000,
  parameter int unsigned T_INIT   = 20000,
  parameter int unsigned T_CMD    = 400,
  parameter int unsigned STRB_CYC = 8
)(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       buf_we,
  input  logic [4:0] buf_addr,
  input  logic [7:0] buf_data,
  input  logic       reinit,
  output logic       ready,
  output logic       busy,
  output logic       lcd_init,
  output logic       lcd_dr,
  output logic       lcd_wr,
  output logic [7:0] lcd_direc,
  output logic [7:0] lcd_dbi,
  output lcd_state_e o_dbg_state
);
  // buf_we is a fire-and-forget valid: every asserted cycle writes, there is no ready/back-pressure.
  lcd_state_e       r_state, w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [31:0]      w_cnt_p1;
  logic [COL_W-1:0] r_col, w_col_rd;
  logic             r_line, r_reinit_pend, r_ready, r_busy;
  logic             r_init, r_dr, r_wr;
  logic [7:0]       r_direc, r_dbi, w_rdata;
  logic [1:0]       w_dirty;
  logic             w_pick, w_pick_line, w_init_done, w_cnt_clr;

  lcd_char_buf u_buf (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .i_we       (buf_we),
    .i_waddr    (buf_addr),
    .i_wdata    (buf_data),
    .i_raddr    ({r_line, w_col_rd}),
    .o_rdata    (w_rdata),
    .i_clr_en   (w_pick),
    .i_clr_line (w_pick_line),
    .i_set_all  (w_init_done),
    .o_dirty    (w_dirty)
  );

  // Waits compare (count+1) >= limit so a limit of 0 or 1 still spends exactly one cycle.
  assign w_cnt_p1    = {{(32-CNT_W){1'b0}}, r_cnt} + 32'd1;
  assign w_pick      = (r_state == ST_IDLE) && !r_reinit_pend && (w_dirty != 2'b00);
  assign w_pick_line = !w_dirty[0];
  assign w_init_done = (r_state == ST_INIT_W) && (w_cnt_p1 >= T_INIT);
  assign w_col_rd    = (r_state == ST_CHAR_W) ? r_col + COL_W'(1) : r_col;

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      ST_PWRUP:  if (w_cnt_p1 >= T_PWRUP)  w_state_nxt = ST_INIT_S;
      ST_INIT_S: if (w_cnt_p1 >= STRB_CYC) w_state_nxt = ST_INIT_W;
      ST_INIT_W: if (w_init_done)          w_state_nxt = ST_IDLE;
      ST_IDLE: begin
        if (r_reinit_pend) w_state_nxt = ST_INIT_S;
        else if (w_pick)   w_state_nxt = ST_ADDR_S;
      end
      ST_ADDR_S: if (w_cnt_p1 >= STRB_CYC) w_state_nxt = ST_ADDR_W;
      ST_ADDR_W: if (w_cnt_p1 >= T_CMD)    w_state_nxt = ST_CHAR_S;
      ST_CHAR_S: if (w_cnt_p1 >= STRB_CYC) w_state_nxt = ST_CHAR_W;
      ST_CHAR_W: begin
        if (w_cnt_p1 >= T_CMD) w_state_nxt = (r_col == '1) ? ST_IDLE : ST_CHAR_S;
      end
      default: w_state_nxt = ST_PWRUP;
    endcase
  end

  // The counter keeps running from a strobe state into its wait state, so settle is measured from strobe start.
  assign w_cnt_clr = (w_state_nxt != r_state) &&
                     !(w_state_nxt inside {ST_INIT_W, ST_ADDR_W, ST_CHAR_W});

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state       <= ST_PWRUP;
      r_cnt         <= '0;
      r_col         <= '0;
      r_line        <= 1'b0;
      r_reinit_pend <= 1'b0;
      r_ready       <= 1'b0;
      r_busy        <= 1'b1;
      r_init        <= 1'b0;
      r_dr          <= 1'b0;
      r_wr          <= 1'b0;
      r_direc       <= 8'h00;
      r_dbi         <= 8'h00;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_clr ? '0 : r_cnt + CNT_W'(1);
      if (w_init_done)  r_reinit_pend <= 1'b0;
      else if (reinit)  r_reinit_pend <= 1'b1;
      if (w_init_done)  r_ready <= 1'b1;
      if (w_pick) begin
        r_line  <= w_pick_line;
        r_col   <= '0;
        r_direc <= ddram_cmd(w_pick_line);
      end
      if (r_state == ST_CHAR_W && w_state_nxt == ST_CHAR_S) r_col <= r_col + COL_W'(1);
      if (w_state_nxt == ST_CHAR_S && r_state != ST_CHAR_S) r_dbi <= w_rdata;
      r_init <= (w_state_nxt == ST_INIT_S);
      r_dr   <= (w_state_nxt == ST_ADDR_S);
      r_wr   <= (w_state_nxt == ST_CHAR_S);
      r_busy <= (w_state_nxt != ST_IDLE);
    end
  end

  assign ready       = r_ready;
  assign busy        = r_busy;
  assign lcd_init    = r_init;
  assign lcd_dr      = r_dr;
  assign lcd_wr      = r_wr;
  assign lcd_direc   = r_direc;
  assign lcd_dbi     = r_dbi;
  assign o_dbg_state = r_state;
endmodule

// File: tb/tb_lcd_refresh_ctrl.sv
// Bench for lcd_refresh_ctrl: directed writes/reinit/reset, strobe scoreboard with timing checks.
module tb_lcd_refresh_ctrl;
  import lcd_pkg::*;

  localparam int unsigned T_PWRUP  = 30;
  localparam int unsigned T_INIT   = 24;
  localparam int unsigned T_CMD    = 12;
  localparam int unsigned STRB_CYC = 3;
  localparam int          W        = 10;
  localparam int          BUDGET   = 5000;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       buf_we = 1'b0;
  logic [4:0] buf_addr = 5'h00;
  logic [7:0] buf_data = 8'h00;
  logic       reinit = 1'b0;
  logic       ready, busy, lcd_init, lcd_dr, lcd_wr;
  logic [7:0] lcd_direc, lcd_dbi;
  lcd_state_e dbg_state;

  // Expected strobe events: {kind, byte}; kind 1 = init, 2 = address, 3 = character.
  logic [W-1:0] exp_q[$];
  logic [7:0]   shadow [32];
  int total = 0;
  int bad = 0;
  int cyc = 0;
  int wr_seen = 0;

  lcd_refresh_ctrl #(
    .T_PWRUP (T_PWRUP),
    .T_INIT  (T_INIT),
    .T_CMD   (T_CMD),
    .STRB_CYC(STRB_CYC)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .buf_we     (buf_we),
    .buf_addr   (buf_addr),
    .buf_data   (buf_data),
    .reinit     (reinit),
    .ready      (ready),
    .busy       (busy),
    .lcd_init   (lcd_init),
    .lcd_dr     (lcd_dr),
    .lcd_wr     (lcd_wr),
    .lcd_direc  (lcd_direc),
    .lcd_dbi    (lcd_dbi),
    .o_dbg_state(dbg_state)
  );

  // Clock / cycle counter
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at t=%0t", name, act, req, $time);
    end
  endtask

  // Monitor / scoreboard
  initial begin : mon
    logic [2:0]   s, prev;
    logic [7:0]   cur [3];
    logic [7:0]   held [3];
    int           width [3];
    int           last_cyc, last_kind;
    logic [W-1:0] got;
    prev = 3'b000;
    last_cyc = -1;
    last_kind = 0;
    for (int k = 0; k < 3; k++) begin width[k] = 0; held[k] = 8'h00; end
    forever begin
      @(negedge clk);
      s = {lcd_wr, lcd_dr, lcd_init};
      cur[0] = 8'h00; cur[1] = lcd_direc; cur[2] = lcd_dbi;
      if (!rst_n) begin
        prev = 3'b000;
        last_cyc = -1;
      end else begin
        check("strobe_excl", 32'($countones(s) <= 1), 32'd1);
        for (int k = 0; k < 3; k++) begin
          if (s[k] && !prev[k]) begin
            if (last_cyc >= 0)
              check("strobe_spacing", 32'((cyc - last_cyc) >= int'(last_kind == 0 ? T_INIT : T_CMD)), 32'd1);
            last_cyc = cyc;
            last_kind = k;
            width[k] = 1;
            held[k] = cur[k];
            if (k == 2) wr_seen++;
            got = {2'(k + 1), cur[k]};
            if (exp_q.size() == 0) begin
              total++;
              bad++;
              $display("FAIL unexpected_strobe: got %0h want none at t=%0t", got, $time);
            end else begin
              check("strobe_seq", 32'(got), 32'(exp_q.pop_front()));
            end
          end else if (s[k] && prev[k]) begin
            width[k]++;
            if (k != 0) check("byte_stable", 32'(cur[k]), 32'(held[k]));
          end else if (!s[k] && prev[k]) begin
            check("strobe_width", 32'(width[k]), 32'(STRB_CYC));
            if (k != 0) check("byte_after", 32'(cur[k]), 32'(held[k]));
          end
        end
        prev = s;
      end
    end
  end

  // Driver tasks
  task automatic bus_write(input logic [4:0] a, input logic [7:0] d);
    buf_we = 1'b1;
    buf_addr = a;
    buf_data = d;
    @(posedge clk);
    #1;
    buf_we = 1'b0;
  endtask

  task automatic push_init();
    exp_q.push_back({2'd1, 8'h00});
  endtask

  task automatic push_line(input logic line);
    exp_q.push_back({2'd2, line ? 8'hC0 : 8'h80});
    for (int c = 0; c < 16; c++) exp_q.push_back({2'd3, shadow[{line, 4'(c)}]});
  endtask

  task automatic wait_wr(input int target, input string name);
    int n;
    n = 0;
    while (wr_seen < target && n < BUDGET) begin @(negedge clk); n++; end
    check(name, 32'(n < BUDGET), 32'd1);
  endtask

  task automatic wait_quiet(input string name);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || busy) && n < BUDGET) begin @(negedge clk); n++; end
    check(name, 32'(n < BUDGET), 32'd1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ready"}, 32'(ready), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd1);
    check({tag, "_init"}, 32'(lcd_init), 32'd0);
    check({tag, "_dr"}, 32'(lcd_dr), 32'd0);
    check({tag, "_wr"}, 32'(lcd_wr), 32'd0);
    check({tag, "_direc"}, 32'(lcd_direc), 32'd0);
    check({tag, "_dbi"}, 32'(lcd_dbi), 32'd0);
  endtask

  initial begin : stim
    int n, base;
    for (int i = 0; i < 32; i++) shadow[i] = 8'h20;

    // 1: power-up, init timing, blank refresh of both lines
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("rst");
    push_init();
    push_line(1'b0);
    push_line(1'b1);
    rst_n = 1'b1;
    n = 0;
    while (!lcd_init && n < 1000) begin @(negedge clk); n++; end
    check("pwrup_delay", 32'(n), 32'(T_PWRUP + 1));
    n = 0;
    while (!ready && n < 1000) begin @(negedge clk); n++; end
    check("ready_delay", 32'(n), 32'(T_INIT));
    wait_quiet("t1_done");
    check("t1_ready", 32'(ready), 32'd1);
    check("t1_busy", 32'(busy), 32'd0);

    // 2: single char on line 1, column 3
    shadow[5'h13] = 8'h41;
    push_line(1'b1);
    bus_write(5'h13, 8'h41);
    wait_quiet("t2_done");

    // 3: both lines dirty at once -> line 0 before line 1
    shadow[5'h05] = 8'h45;
    push_line(1'b0);
    shadow[5'h10] = 8'h42;
    shadow[5'h00] = 8'h43;
    push_line(1'b0);
    push_line(1'b1);
    base = wr_seen;
    bus_write(5'h05, 8'h45);
    wait_wr(base + 2, "t3_wait");
    bus_write(5'h10, 8'h42);
    bus_write(5'h00, 8'h43);
    wait_quiet("t3_done");

    // 4: writes mid-pass: unsent column shows now, sent column forces a resend
    shadow[5'h00] = 8'h44;
    shadow[5'h0A] = 8'h58;
    push_line(1'b0);
    shadow[5'h01] = 8'h59;
    push_line(1'b0);
    base = wr_seen;
    bus_write(5'h00, 8'h44);
    wait_wr(base + 4, "t4_wait");
    repeat (STRB_CYC + 1) @(posedge clk);
    #1;
    bus_write(5'h0A, 8'h58);
    bus_write(5'h01, 8'h59);
    wait_quiet("t4_done");

    // 5: reinit during a pass -> pass completes, init, full refresh
    shadow[5'h1F] = 8'h5A;
    push_line(1'b1);
    push_init();
    push_line(1'b0);
    push_line(1'b1);
    base = wr_seen;
    bus_write(5'h1F, 8'h5A);
    wait_wr(base + 2, "t5_wait");
    reinit = 1'b1;
    @(posedge clk);
    #1;
    reinit = 1'b0;
    wait_quiet("t5_done");
    check("t5_ready", 32'(ready), 32'd1);

    // 6: reset in the middle of a character strobe
    shadow[5'h02] = 8'h51;
    push_line(1'b0);
    base = wr_seen;
    bus_write(5'h02, 8'h51);
    wait_wr(base + 3, "t6_wait");
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    check("t6_wr", 32'(lcd_wr), 32'd0);
    check("t6_init", 32'(lcd_init), 32'd0);
    check("t6_dr", 32'(lcd_dr), 32'd0);
    check("t6_ready", 32'(ready), 32'd0);
    check("t6_busy", 32'(busy), 32'd1);
    check("t6_state", 32'(dbg_state), 32'(ST_PWRUP));
    exp_q.delete();
    for (int i = 0; i < 32; i++) shadow[i] = 8'h20;
    push_init();
    push_line(1'b0);
    push_line(1'b1);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    wait_quiet("t6_done");
    check("t6_ready_again", 32'(ready), 32'd1);

    check("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
